// File: rtl/mem_stage_ctrl.sv
// MEM-stage access sequencer: runs loads/stores against a req/ready data memory,
// stalls the front of the pipe while busy and gates the MEM/WB enable and halt.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic        i_haltIn,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ready,
    output logic        o_mem_req,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    output logic [15:0] o_memData,
    output logic        o_memwbEn,
    output logic        o_haltOut,
    output logic        o_stall,
    output logic        o_halted,
    output logic        o_err
);

    // state | meaning
    // IDLE  | pass-through; launches an access or latches a halt
    // BUSY  | request outstanding, waiting for mem_ready
    // DONE  | access complete, MEM/WB captures for one cycle
    // ERR   | memory timed out, frozen until reset
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_count;
    logic               r_req;
    logic               r_wr;
    logic [15:0]        r_addr;
    logic [15:0]        r_wdata;
    logic [15:0]        r_data;
    logic               r_halted;
    logic               w_access;
    logic               w_timeout;

    assign w_access  = i_memRead | i_memWrite;
    assign w_timeout = (r_count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_req    <= 1'b0;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_data   <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (!r_halted) begin
                        if (w_access) begin
                            r_addr  <= i_addr;
                            r_wdata <= i_wdata;
                            r_wr    <= i_memWrite;
                            r_count <= '0;
                            r_req   <= 1'b1;
                        end else if (i_haltIn) begin
                            r_halted <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_count <= r_count + 1'b1;
                    if (i_mem_ready) begin
                        r_req <= 1'b0;
                        if (!r_wr) begin
                            r_data <= i_mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_req <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        o_stall   = 1'b1;
        o_memwbEn = 1'b0;
        o_haltOut = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_halted) begin
                    if (w_access) begin
                        w_next = S_BUSY;
                    end else begin
                        o_stall   = 1'b0;
                        o_memwbEn = 1'b1;
                        o_haltOut = i_haltIn;
                    end
                end
            end
            S_BUSY: begin
                // a completion on the last allowed cycle still counts as success
                if (i_mem_ready) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                o_stall   = 1'b0;
                o_memwbEn = 1'b1;
                w_next    = S_IDLE;
            end
            default: begin
            end
        endcase
    end

    assign o_mem_req   = r_req;
    assign o_mem_wr    = r_wr;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_memData   = r_data;
    assign o_halted    = r_halted;
    assign o_err       = (r_state == S_ERR);

endmodule
